// File: rtl/weight_loader_if.sv
// Purpose: word stream in, shared weight-memory write bus plus status out.
// Latency: none, this is wiring only.
// Backpressure: s_ready qualifies s_valid; the write side has no flow control.
interface weight_loader_if #(
    parameter int numNeuron    = 30,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16
);
    logic                    s_valid;
    logic                    s_ready;
    logic [dataWidth-1:0]    s_data;
    logic [numNeuron-1:0]    wen;
    logic [addressWidth-1:0] wadd;
    logic [dataWidth-1:0]    win;
    logic                    done;
    logic                    err;

    // Host side: offers words, observes the loader outputs.
    modport master (
        output s_valid, s_data,
        input  s_ready, wen, wadd, win, done, err
    );

    // Loader side.
    modport slave (
        input  s_valid, s_data,
        output s_ready, wen, wadd, win, done, err
    );
endinterface

// File: rtl/weight_loader.sv
// Purpose: parse header + numWeight words, write them to one neuron's weight memory.
// Latency: 1 cycle from accepted weight to wen/wadd/win; done with the last write.
// Backpressure: s_ready drops for the single DONE cycle per packet; s_valid gaps just stall.
module weight_loader #(
    parameter int numNeuron      = 30,
    parameter int numWeight      = 784,
    parameter int addressWidth   = 10,
    parameter int dataWidth      = 16,
    parameter int neuronSelWidth = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    weight_loader_if.slave bus
);
    typedef enum logic [1:0] {HDR, LOAD, DONE} state_t;

    localparam logic [addressWidth-1:0] LAST_W = addressWidth'(numWeight - 1);
    localparam logic [addressWidth-1:0] ONE_W  = addressWidth'(1);
    localparam logic [numNeuron-1:0]    ONE_N  = numNeuron'(1);

    state_t                    state;
    logic [addressWidth-1:0]   wcnt;
    logic [neuronSelWidth-1:0] sel;
    logic                      drop;

    logic                      ready_q;
    logic [numNeuron-1:0]      wen_q;
    logic [addressWidth-1:0]   wadd_q;
    logic [dataWidth-1:0]      win_q;
    logic                      done_q;
    logic                      err_q;

    logic                      accept;
    logic [neuronSelWidth-1:0] hdr_sel;
    logic                      hdr_bad;

    // s_ready comes straight from a flop, so s_valid never reaches it combinationally.
    assign accept  = bus.s_valid && ready_q;
    // Header bits above the selector field are don't-care.
    assign hdr_sel = bus.s_data[neuronSelWidth-1:0];
    assign hdr_bad = (int'(hdr_sel) >= numNeuron);

    assign bus.s_ready = ready_q;
    assign bus.wen     = wen_q;
    assign bus.wadd    = wadd_q;
    assign bus.win     = win_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

    // Packet FSM with all outputs registered; wadd/win hold between writes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= HDR;
            wcnt    <= '0;
            sel     <= '0;
            drop    <= 1'b0;
            ready_q <= 1'b0;
            wen_q   <= '0;
            wadd_q  <= '0;
            win_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            wen_q  <= '0;
            done_q <= 1'b0;
            case (state)
                HDR: begin
                    ready_q <= 1'b1;
                    if (accept) begin
                        sel   <= hdr_sel;
                        drop  <= hdr_bad;
                        wcnt  <= '0;
                        state <= LOAD;
                        if (hdr_bad) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        // A dropped packet still walks the address, but no memory sees wen.
                        wadd_q <= wcnt;
                        win_q  <= bus.s_data;
                        wen_q  <= drop ? '0 : (ONE_N << sel);
                        if (wcnt == LAST_W) begin
                            wcnt    <= '0;
                            state   <= DONE;
                            done_q  <= 1'b1;
                            ready_q <= 1'b0;
                        end else begin
                            wcnt <= wcnt + ONE_W;
                        end
                    end
                end
                DONE: begin
                    state   <= HDR;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= HDR;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
